count_enable_gen: RTL and testbench

//  Upstream clock-enable source for the decade counter chain.
//  - Divides the board clock into a 1-cycle CE pulse every DIV cycles.
//  - Start/stop is a debounced pushbutton toggle.
//  - Single-step is a second debounced pushbutton that emits exactly one CE while stopped.
//  - CE drives the units-digit counter's CE input directly; both blocks share CLK and RST.

---
 rtl/count_enable_gen.sv | 172 +++++++++++++++++
 tb/tb_count_enable_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_enable_gen.sv
// count_enable_gen
//   Clock-enable source for the decade counter chain. While running, emits a
//   one-cycle CE pulse every DIV clock cycles. A debounced start/stop button
//   toggles between RUN and STOP; a debounced single-step button emits exactly
//   one CE while stopped. The prescaler keeps its phase across a pause.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous reset, active-low
//   BTN_SS    in   raw start/stop button, active-high, asynchronous to CLK
//   BTN_STEP  in   raw single-step button, active-high, asynchronous to CLK
//   CE        out  registered count enable, one-cycle pulses
//   RUN       out  registered run status (1 = RUN, 0 = STOP); this is the FSM state
//
// Handshake: none. Press pulses from the debouncers are single-cycle events
// consumed by the FSM on the clock edge that ends the pulse cycle.

// Button conditioner: 2-FF synchronizer, level debouncer and press detector.
//   clk_i    in   clock
//   rst_ni   in   asynchronous reset, active-low
//   btn_i    in   raw button level
//   press_o  out  one-cycle flag, high in the cycle the debounced level goes 0->1
module count_enable_gen_db #(
    parameter int DB_CYCLES = 20000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    // The counter only needs to reach DB_CYCLES-1: acceptance happens on the
    // cycle that would have taken it to DB_CYCLES.
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          differ;
    logic          accept;

    assign differ = sync2_q ^ level_q;
    assign accept = differ && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!differ) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d   = '0;
            level_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Press is flagged combinationally in the acceptance cycle so the FSM
    // reacts on the same edge that updates the debounced level.
    assign press_o = accept & sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

module count_enable_gen #(
    parameter int DIV       = 1000,
    parameter int DB_CYCLES = 20000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_SS,
    input  logic BTN_STEP,
    output logic CE,
    output logic RUN
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          ce_q;
    logic          ce_d;
    logic          ss_press;
    logic          step_press;

    count_enable_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .btn_i   (BTN_SS),
        .press_o (ss_press)
    );

    count_enable_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .btn_i   (BTN_STEP),
        .press_o (step_press)
    );

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        ce_d    = 1'b0;
        case (state_q)
            ST_STOP: begin
                // Start/stop takes priority over a coincident step press.
                if (ss_press) begin
                    state_d = ST_RUN;
                end else if (step_press) begin
                    ce_d = 1'b1;
                end
            end
            ST_RUN: begin
                // The prescaler advances on the stopping edge too, so a wrap
                // that coincides with the stop press still yields its CE.
                if (pcnt_q == PCNT_MAX) begin
                    pcnt_d = '0;
                    ce_d   = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
                if (ss_press) begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_STOP;
            pcnt_q  <= '0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            ce_q    <= ce_d;
        end
    end

    assign CE  = ce_q;
    assign RUN = (state_q == ST_RUN);

endmodule

// File: tb/tb_count_enable_gen.sv
module tb_count_enable_gen;

    localparam int DIV = 5;
    localparam int DB  = 4;

    logic CLK;
    logic RST;
    logic BTN_SS;
    logic BTN_STEP;
    logic CE;
    logic RUN;

    int errors = 0;
    int checks = 0;
    int ce_cnt = 0;
    int run_tog = 0;
    logic run_prev = 1'b0;

    count_enable_gen #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_SS   (BTN_SS),
        .BTN_STEP (BTN_STEP),
        .CE       (CE),
        .RUN      (RUN)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    // Per button: raw level passes through a two-sample delay line; a run of
    // DB consecutive samples disagreeing with the accepted level flips it.
    // Machine: a running flag and a phase counted modulo DIV.
    bit m_d1[2];
    bit m_d2[2];
    bit m_lvl[2];
    int m_streak[2];
    int m_phase = 0;
    bit m_run = 1'b0;
    bit m_ce = 1'b0;

    always @(posedge CLK or negedge RST) begin : model_upd
        bit raw[2];
        bit prs[2];
        if (!RST) begin
            for (int b = 0; b < 2; b++) begin
                m_d1[b] = 1'b0;
                m_d2[b] = 1'b0;
                m_lvl[b] = 1'b0;
                m_streak[b] = 0;
            end
            m_phase = 0;
            m_run = 1'b0;
            m_ce = 1'b0;
        end else begin
            raw[0] = BTN_SS;
            raw[1] = BTN_STEP;
            for (int b = 0; b < 2; b++) begin
                prs[b] = 1'b0;
                if (m_d2[b] != m_lvl[b]) begin
                    m_streak[b]++;
                    if (m_streak[b] == DB) begin
                        m_lvl[b] = m_d2[b];
                        m_streak[b] = 0;
                        prs[b] = m_lvl[b];
                    end
                end else begin
                    m_streak[b] = 0;
                end
                m_d2[b] = m_d1[b];
                m_d1[b] = raw[b];
            end
            m_ce = 1'b0;
            if (m_run) begin
                m_phase = (m_phase + 1) % DIV;
                if (m_phase == 0) m_ce = 1'b1;
                if (prs[0]) m_run = 1'b0;
            end else if (prs[0]) begin
                m_run = 1'b1;
            end else if (prs[1]) begin
                m_ce = 1'b1;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("ce_cycle", int'(CE), int'(m_ce));
        chk("run_cycle", int'(RUN), int'(m_run));
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            if (CE) ce_cnt++;
            if (RUN != run_prev) run_tog++;
            run_prev = RUN;
        end
    endtask

    task automatic press(input bit ss, input bit st, input int hold);
        BTN_SS = ss;
        BTN_STEP = st;
        tick(hold);
        BTN_SS = 1'b0;
        BTN_STEP = 1'b0;
        tick(8);
    endtask

    // Cycles until RUN equals v; -1 when the budget expires.
    task automatic wait_run(input bit v, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget && n < 0; k++) begin
            @(negedge CLK);
            if (RUN == v) n = k;
        end
        run_prev = RUN;
    endtask

    // Cycles until CE is seen high; -1 when the budget expires.
    task automatic wait_ce(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget && n < 0; k++) begin
            @(negedge CLK);
            if (CE) n = k;
        end
        run_prev = RUN;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int bp[5];
        RST = 1'b0;
        BTN_SS = 1'b0;
        BTN_STEP = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_ce", int'(CE), 0);
        chk("reset_run", int'(RUN), 0);
        RST = 1'b1;

        // 1. Idle after reset.
        ce_cnt = 0; run_tog = 0;
        tick(50);
        chk("idle_ce_count", ce_cnt, 0);
        chk("idle_run_toggles", run_tog, 0);

        // 2. Start with a 10-cycle press; RUN after sync (2) + debounce (DB).
        BTN_SS = 1'b1;
        wait_run(1'b1, DB + 4, n);
        chk("start_latency", n, DB + 2);
        fork
            begin
                tick(4);
                BTN_SS = 1'b0;
            end
        join_none
        wait_ce(8, n);
        chk("first_ce_after_run", n, 5);
        wait_ce(8, n);
        chk("ce_spacing_a", n, 5);
        wait_ce(8, n);
        chk("ce_spacing_b", n, 5);
        tick(10);

        // 3. Glitch shorter than the debounce period, then a bounce train.
        run_tog = 0;
        BTN_SS = 1'b1;
        tick(3);
        BTN_SS = 1'b0;
        tick(12);
        chk("glitch_no_toggle", run_tog, 0);
        bp = '{1, 0, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            BTN_SS = bp[i][0];
            tick(1);
        end
        BTN_SS = 1'b1;
        tick(10);
        BTN_SS = 1'b0;
        tick(12);
        chk("bounce_one_toggle", run_tog, 1);
        chk("bounce_stopped", int'(RUN), 0);

        // 4. Park at phase 2, single-step, then resume from the held phase.
        press(1'b1, 1'b0, 6);
        wait_ce(10, n);
        tick(1);
        press(1'b1, 1'b0, 6);
        chk("stopped_again", int'(RUN), 0);
        chk("model_phase_at_stop", m_phase, 2);
        ce_cnt = 0; run_tog = 0;
        press(1'b0, 1'b1, 6);
        tick(10);
        chk("step_ce_count", ce_cnt, 1);
        chk("step_run_toggles", run_tog, 0);
        chk("model_phase_after_step", m_phase, 2);
        BTN_SS = 1'b1;
        wait_run(1'b1, DB + 4, n);
        chk("resume_latency", n, DB + 2);
        wait_ce(8, n);
        chk("resume_first_ce", n, 3);
        BTN_SS = 1'b0;
        tick(8);

        // 5a. Stop press landing on the wrap edge still yields its CE.
        wait_ce(10, n);
        tick(4);
        BTN_SS = 1'b1;
        wait_run(1'b0, DB + 4, n);
        chk("stop_on_wrap_latency", n, DB + 2);
        chk("ce_on_stop_edge", int'(CE), 1);
        BTN_SS = 1'b0;
        tick(8);
        // 5b. Start and step together: start wins.
        BTN_SS = 1'b1;
        BTN_STEP = 1'b1;
        wait_run(1'b1, DB + 4, n);
        chk("ss_step_latency", n, DB + 2);
        chk("no_step_ce", int'(CE), 0);
        wait_ce(8, n);
        chk("ss_wins_first_ce", n, 5);
        BTN_SS = 1'b0;
        BTN_STEP = 1'b0;
        tick(8);

        // 6. Asynchronous reset at phase 3, then a button held through release.
        wait_ce(10, n);
        tick(3);
        #2;
        RST = 1'b0;
        #1;
        chk("async_reset_run", int'(RUN), 0);
        chk("async_reset_ce", int'(CE), 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        run_prev = RUN;
        ce_cnt = 0; run_tog = 0;
        tick(30);
        chk("post_reset_ce_count", ce_cnt, 0);
        chk("post_reset_run_toggles", run_tog, 0);
        BTN_SS = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        tick(2);
        RST = 1'b1;
        wait_run(1'b1, DB + 4, n);
        chk("held_through_reset", n, DB + 2);
        wait_ce(8, n);
        chk("post_reset_phase0", n, 5);
        BTN_SS = 1'b0;
        tick(8);

        // 7. Random button activity with occasional resets.
        for (int i = 0; i < 600; i++) begin
            BTN_SS = 1'($urandom_range(0, 1));
            BTN_STEP = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 10));
            if ($urandom_range(0, 59) == 0) begin
                #2;
                RST = 1'b0;
                @(negedge CLK);
                RST = 1'b1;
                run_prev = RUN;
            end
        end
        BTN_SS = 1'b0;
        BTN_STEP = 1'b0;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
